uart_word_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_word_transmitter.sv | 132 +++++++++++++
 tb/tb_uart_word_transmitter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-packed UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS     = 8;
  localparam logic [15:0] UART_DEFAULT_WTIME = 16'h364;

endpackage

// File: rtl/uart_word_transmitter.sv
// 8N1 UART transmitter: sends a BYTES-wide word LSB-byte first over tx,
// each bit held WTIME clocks, with a valid/ready intake handshake.
module uart_word_transmitter
  import uart_pkg::*;
#(
  parameter logic [15:0] WTIME = UART_DEFAULT_WTIME,
  parameter int unsigned BYTES = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BYTES*UART_DATA_BITS-1:0]  data,
  input  logic                             valid,
  output logic                             ready,
  output logic                             tx,
  output logic                             busy
);

  localparam int unsigned WORD_W = BYTES * UART_DATA_BITS;
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
  localparam int unsigned BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  uart_tx_state_t      state, state_d;
  logic [15:0]         baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]    bit_idx, bit_idx_d;
  logic [BYTE_W-1:0]   byte_idx, byte_idx_d;
  logic [WORD_W-1:0]   word, word_d;
  logic                ready_d, busy_d, tx_d;
  logic                baud_end_c;

  assign baud_end_c = (baud_cnt == (WTIME - 16'd1));

  // State and registered outputs; tx idles high straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      word     <= word_d;
      ready    <= ready_d;
      busy     <= busy_d;
      tx       <= tx_d;
    end
  end

  // Next-state logic; the word shifts right once per data bit so word[0]
  // is always the bit on the line and the next byte slides into place.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    word_d     = word;
    ready_d    = ready;
    busy_d     = busy;
    tx_d       = 1'b1;

    unique case (state)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (valid && ready) begin
          word_d     = data;
          byte_idx_d = '0;
          baud_cnt_d = '0;
          state_d    = START;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (baud_end_c) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        if (baud_end_c) begin
          baud_cnt_d = '0;
          word_d     = word >> 1;
          if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end

      STOP: begin
        if (baud_end_c) begin
          baud_cnt_d = '0;
          if (byte_idx != BYTE_W'(BYTES - 1)) begin
            byte_idx_d = byte_idx + BYTE_W'(1);
            state_d    = START;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered, so tx leads by no cycle.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = word_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_word_transmitter.sv
// Bench for uart_word_transmitter: five configurations checked cycle by cycle
// against a frame model built from the 8N1 framing rules.
module tb_uart_word_transmitter;

  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_a  [NI];
  logic        valid_a [NI];
  logic        ready_a [NI];
  logic        tx_a    [NI];
  logic        busy_a  [NI];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word_transmitter #(.WTIME(16'd4), .BYTES(1)) u0 (
    .clk(clk), .rst(rst), .data(data_a[0][7:0]), .valid(valid_a[0]),
    .ready(ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0]));
  uart_word_transmitter #(.WTIME(16'd4), .BYTES(2)) u1 (
    .clk(clk), .rst(rst), .data(data_a[1]), .valid(valid_a[1]),
    .ready(ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1]));
  uart_word_transmitter #(.WTIME(16'd2), .BYTES(1)) u2 (
    .clk(clk), .rst(rst), .data(data_a[2][7:0]), .valid(valid_a[2]),
    .ready(ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2]));
  uart_word_transmitter #(.WTIME(16'd3), .BYTES(1)) u3 (
    .clk(clk), .rst(rst), .data(data_a[3][7:0]), .valid(valid_a[3]),
    .ready(ready_a[3]), .tx(tx_a[3]), .busy(busy_a[3]));
  uart_word_transmitter #(.WTIME(16'd1), .BYTES(1)) u4 (
    .clk(clk), .rst(rst), .data(data_a[4][7:0]), .valid(valid_a[4]),
    .ready(ready_a[4]), .tx(tx_a[4]), .busy(busy_a[4]));

  function automatic int nb_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int wt_of(input int k);
    case (k)
      0, 1:    return 4;
      2:       return 2;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  // Line level j cycles into a frame: per byte a start 0, 8 data bits LSB first, a stop 1.
  function automatic logic exp_tx(input logic [15:0] word, input int w, input int j);
    int slot, byte_i, pos;
    slot   = j / w;
    byte_i = slot / 10;
    pos    = slot % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return word[byte_i*8 + pos - 1];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_all(input string tag, input logic exp_ready);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_u%0d_tx", tag, k), 32'(tx_a[k]), 32'd1);
      check($sformatf("%s_u%0d_ready", tag, k), 32'(ready_a[k]), 32'(exp_ready));
      check($sformatf("%s_u%0d_busy", tag, k), 32'(busy_a[k]), 32'd0);
    end
  endtask

  // Assert rst between edges, hold it, release, and expect ready one edge later.
  task automatic do_reset(input string tag, input int hold);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_idle_all({tag, "_async"}, 1'b0);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_all({tag, "_released"}, 1'b0);
    @(posedge clk); #1;
    check_idle_all({tag, "_ready"}, 1'b1);
  endtask

  // Offer a word, follow the whole frame, and check the return to idle.
  task automatic send_word(input int k, input logic [15:0] word, input bit keep_valid,
                           input int mid_at, input logic [15:0] mid_data, output int start_cyc);
    int w, n, waited;
    w = wt_of(k);
    n = nb_of(k) * 10 * w;
    waited = 0;
    data_a[k]  = word;
    valid_a[k] = 1'b1;
    while (ready_a[k] !== 1'b1 && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    check($sformatf("u%0d_ready_before_accept", k), 32'(ready_a[k]), 32'd1);
    @(posedge clk); #1;
    start_cyc = cyc;
    if (!keep_valid) valid_a[k] = 1'b0;
    for (int j = 0; j < n; j++) begin
      check($sformatf("u%0d_w%0h_tx_c%0d", k, word, j), 32'(tx_a[k]), 32'(exp_tx(word, w, j)));
      check($sformatf("u%0d_w%0h_busy_c%0d", k, word, j), 32'(busy_a[k]), 32'd1);
      check($sformatf("u%0d_w%0h_ready_c%0d", k, word, j), 32'(ready_a[k]), 32'd0);
      if (j == mid_at) begin
        data_a[k] = mid_data;
        if (!keep_valid) valid_a[k] = 1'b1;
      end
      if (j == mid_at + 1 && !keep_valid) valid_a[k] = 1'b0;
      @(posedge clk); #1;
    end
    check($sformatf("u%0d_w%0h_end_tx", k, word), 32'(tx_a[k]), 32'd1);
    check($sformatf("u%0d_w%0h_end_busy", k, word), 32'(busy_a[k]), 32'd0);
    check($sformatf("u%0d_w%0h_end_ready", k, word), 32'(ready_a[k]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, k, gap;
    logic [15:0] word;
    for (int i = 0; i < NI; i++) begin
      data_a[i]  = '0;
      valid_a[i] = 1'b0;
    end

    // Power-on reset held for 5 cycles.
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_idle_all("por", 1'b0);
    rst = 1'b0;
    check_idle_all("por_released", 1'b0);
    @(posedge clk); #1;
    check_idle_all("por_ready", 1'b1);

    // Reset asserted between edges while idle.
    do_reset("idle_rst", 5);

    // Single byte and two-byte word.
    send_word(0, 16'h00A5, 1'b0, -1, 16'h0, s1);
    send_word(1, 16'h3C5A, 1'b0, -1, 16'h0, s1);
    send_word(4, 16'h00C3, 1'b0, -1, 16'h0, s1);

    // Back-to-back with valid held high.
    send_word(2, 16'h0001, 1'b1, 3, 16'h0080, s1);
    send_word(2, 16'h0080, 1'b0, -1, 16'h0, s2);
    check("b2b_start_spacing", 32'(s2 - s1), 32'd21);

    // Data toggle and valid pulse mid-frame must be ignored.
    send_word(3, 16'h00F0, 1'b0, 5, 16'h000F, s1);
    for (int j = 0; j < 40; j++) begin
      check($sformatf("iso_no_frame_tx_c%0d", j), 32'(tx_a[3]), 32'd1);
      check($sformatf("iso_no_frame_busy_c%0d", j), 32'(busy_a[3]), 32'd0);
      @(posedge clk); #1;
    end

    // Reset during data bit 3 of 8'hFF.
    data_a[0]  = 16'h00FF;
    valid_a[0] = 1'b1;
    @(posedge clk); #1;
    valid_a[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("midframe_busy_before_rst", 32'(busy_a[0]), 32'd1);
    do_reset("mid_rst", 3);
    send_word(0, 16'h0055, 1'b0, -1, 16'h0, s1);

    // Reset during a start bit: tx must leave 0 without a clock edge.
    data_a[1]  = 16'h0000;
    valid_a[1] = 1'b1;
    @(posedge clk); #1;
    valid_a[1] = 1'b0;
    check("start_rst_tx_low", 32'(tx_a[1]), 32'd0);
    do_reset("start_rst", 2);
    send_word(1, 16'hA55A, 1'b0, -1, 16'h0, s1);

    // Randomized words across all configurations.
    repeat (30) begin
      k    = int'($urandom_range(0, NI - 1));
      word = 16'($urandom);
      if (nb_of(k) == 1) word[15:8] = 8'h00;
      gap  = int'($urandom_range(0, 3));
      for (int j = 0; j < gap; j++) begin
        check($sformatf("rnd_gap_u%0d_tx", k), 32'(tx_a[k]), 32'd1);
        @(posedge clk); #1;
      end
      send_word(k, word, 1'b0, -1, 16'h0, s1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
